// File: rtl/display_pkg.sv
// Shared display timing definitions: the 640x480p60 mode and a mode descriptor
// type for adding further video modes later.
package display_pkg;

  typedef struct packed {
    int   active;
    int   fp;
    int   sync;
    int   bp;
    logic pol;
  } timing_t;

  localparam int CORDW_DEFAULT = 10;

  localparam timing_t H_480P = '{active: 640, fp: 16, sync: 96, bp: 48, pol: 1'b0};
  localparam timing_t V_480P = '{active: 480, fp: 10, sync: 2,  bp: 33, pol: 1'b0};

endpackage

// File: rtl/display_timing_480p.sv
// Raster timing generator: pixel/line counters with registered sync, data-enable,
// line/frame strobes and a frame counter, all aligned to the shown coordinates.
module display_timing_480p
  import display_pkg::*;
#(
  parameter int   CORDW    = CORDW_DEFAULT,
  parameter int   H_ACTIVE = H_480P.active,
  parameter int   H_FP     = H_480P.fp,
  parameter int   H_SYNC   = H_480P.sync,
  parameter int   H_BP     = H_480P.bp,
  parameter int   V_ACTIVE = V_480P.active,
  parameter int   V_FP     = V_480P.fp,
  parameter int   V_SYNC   = V_480P.sync,
  parameter int   V_BP     = V_480P.bp,
  parameter logic H_POL    = H_480P.pol,
  parameter logic V_POL    = V_480P.pol,
  parameter int   FRAMEW   = 16
) (
  input  logic              clk_pix,
  input  logic              rst,
  output logic [CORDW-1:0]  sx,
  output logic [CORDW-1:0]  sy,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              line,
  output logic              frame,
  output logic [FRAMEW-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL - 1) >= (1 << CORDW) || (V_TOTAL - 1) >= (1 << CORDW)) begin : g_cordw_check
    $error("display_timing_480p: CORDW too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT_C  = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT_C  = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CORDW-1:0]  sx_reg, sy_reg, sx_next, sy_next;
  logic              hsync_reg, vsync_reg, de_reg, line_reg, frame_reg;
  logic [FRAMEW-1:0] frame_count_reg;
  logic              frame_next;

  // Every output is derived from the next coordinates so it lines up with sx/sy.
  always_comb begin
    sx_next = sx_reg + CORDW'(1);
    sy_next = sy_reg;
    if (sx_reg == H_LAST) begin
      sx_next = '0;
      sy_next = (sy_reg == V_LAST) ? '0 : sy_reg + CORDW'(1);
    end
    frame_next = (sx_next == '0) && (sy_next == '0);
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx_reg          <= H_LAST;
      sy_reg          <= V_LAST;
      hsync_reg       <= ~H_POL;
      vsync_reg       <= ~V_POL;
      de_reg          <= 1'b0;
      line_reg        <= 1'b0;
      frame_reg       <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      sx_reg          <= sx_next;
      sy_reg          <= sy_next;
      hsync_reg       <= (sx_next >= HS_START && sx_next <= HS_END) ? H_POL : ~H_POL;
      vsync_reg       <= (sy_next >= VS_START && sy_next <= VS_END) ? V_POL : ~V_POL;
      de_reg          <= (sx_next < H_ACT_C) && (sy_next < V_ACT_C);
      line_reg        <= (sx_next == '0);
      frame_reg       <= frame_next;
      if (frame_next) frame_count_reg <= frame_count_reg + FRAMEW'(1);
    end
  end

  assign sx          = sx_reg;
  assign sy          = sy_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign line        = line_reg;
  assign frame       = frame_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_display_timing_480p.sv
// Bench for display_timing_480p: a default-mode instance and a tiny-mode instance
// (FRAMEW=2) driven with random reset pulses and checked against a time-based model.
module tb_display_timing_480p;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  // default 640x480 instance
  logic        rst_a;
  logic [9:0]  sx_a, sy_a;
  logic        hsync_a, vsync_a, de_a, line_a, frame_a;
  logic [15:0] fc_a;

  // tiny mode: 16 x 9 total, positive hsync, 2-bit frame counter
  logic        rst_b;
  logic [4:0]  sx_b, sy_b;
  logic        hsync_b, vsync_b, de_b, line_b, frame_b;
  logic [1:0]  fc_b;

  display_timing_480p u_dut (
    .clk_pix(clk_pix), .rst(rst_a), .sx(sx_a), .sy(sy_a), .hsync(hsync_a),
    .vsync(vsync_a), .de(de_a), .line(line_a), .frame(frame_a), .frame_count(fc_a)
  );

  display_timing_480p #(
    .CORDW(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b1), .V_POL(1'b0), .FRAMEW(2)
  ) u_small (
    .clk_pix(clk_pix), .rst(rst_b), .sx(sx_b), .sy(sy_b), .hsync(hsync_b),
    .vsync(vsync_b), .de(de_b), .line(line_b), .frame(frame_b), .frame_count(fc_b)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // t = cycles since reset release (0 = first cycle after release), -1 = in reset.
  task automatic check_model(
    input string id, input int t,
    input int ha, input int hfp, input int hs, input int hbp,
    input int va, input int vfp, input int vs, input int vbp,
    input bit hpol, input bit vpol, input int fw,
    input logic [31:0] sx, input logic [31:0] sy,
    input logic hsync, input logic vsync, input logic de,
    input logic line, input logic frame, input logic [31:0] fc);
    int ht, vt, ex, ey, efc;
    bit ehs, evs, ede, eln, efr;
    ht = ha + hfp + hs + hbp;
    vt = va + vfp + vs + vbp;
    if (t < 0) begin
      ex = ht - 1; ey = vt - 1;
      ehs = !hpol; evs = !vpol; ede = 0; eln = 0; efr = 0; efc = 0;
    end else begin
      ex  = t % ht;
      ey  = (t / ht) % vt;
      ede = (ex < ha) && (ey < va);
      ehs = (ex >= ha + hfp && ex < ha + hfp + hs) ? hpol : !hpol;
      evs = (ey >= va + vfp && ey < va + vfp + vs) ? vpol : !vpol;
      eln = (ex == 0);
      efr = (t % (ht * vt)) == 0;
      efc = (t / (ht * vt) + 1) % (1 << fw);
    end
    check_eq({id, ".sx"},    sx, 32'(ex));
    check_eq({id, ".sy"},    sy, 32'(ey));
    check_eq({id, ".hsync"}, 32'(hsync), 32'(ehs));
    check_eq({id, ".vsync"}, 32'(vsync), 32'(evs));
    check_eq({id, ".de"},    32'(de), 32'(ede));
    check_eq({id, ".line"},  32'(line), 32'(eln));
    check_eq({id, ".frame"}, 32'(frame), 32'(efr));
    check_eq({id, ".fcount"}, fc, 32'(efc));
  endtask

  initial begin
    int ta = -1, tb = -1;
    int hold_a = 5, hold_b = 5;
    bit pulsed_a = 0, pulsed_b = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      rst_a = (hold_a > 0);
      rst_b = (hold_b > 0);
      @(posedge clk_pix);
      #1;
      ta = rst_a ? -1 : ta + 1;
      tb = rst_b ? -1 : tb + 1;

      check_model("a", ta, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 16,
                  32'(sx_a), 32'(sy_a), hsync_a, vsync_a, de_a, line_a, frame_a, 32'(fc_a));
      check_model("b", tb, 8, 2, 3, 3, 4, 1, 2, 2, 1'b1, 1'b0, 2,
                  32'(sx_b), 32'(sy_b), hsync_b, vsync_b, de_b, line_b, frame_b, 32'(fc_b));

      // Deterministic mid-frame pulses, then sparse random reset pulses.
      if (hold_a > 0) hold_a--;
      else if (!pulsed_a && ta == 2700) begin hold_a = 1; pulsed_a = 1; end
      else if ($urandom_range(2999, 0) == 0) hold_a = $urandom_range(6, 1);

      if (hold_b > 0) hold_b--;
      else if (!pulsed_b && tb == 1000) begin hold_b = 1; pulsed_b = 1; end
      else if (c > 4000 && $urandom_range(399, 0) == 0) hold_b = $urandom_range(6, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
